// File: rtl/counter_pkg.sv
// Shared types and constants for the programmable modulus counter.
package counter_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_next_state.sv
// Combinational step function: the next count value, the terminal-event flag and
// the one-shot halt request, given the current count, modulus, direction and mode.
module counter_next_state
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_mod,
  input  logic             i_up,
  input  logic             i_oneshot,
  output logic [WIDTH-1:0] o_q_next,
  output logic             o_term,
  output logic             o_done_set
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Step rules; an out-of-range count snaps to the start of the range without a terminal event.
  always_comb begin
    o_q_next   = i_q;
    o_term     = 1'b0;
    o_done_set = 1'b0;
    if (i_up == DIR_UP) begin
      if (i_q == i_mod) begin
        o_term = 1'b1;
        if (i_oneshot) begin
          o_done_set = 1'b1;
          o_q_next   = i_q;
        end else begin
          o_q_next = ZERO;
        end
      end else if (i_q > i_mod) begin
        o_q_next = ZERO;
      end else begin
        o_q_next = i_q + ONE;
      end
    end else begin
      if (i_q == ZERO) begin
        o_term = 1'b1;
        if (i_oneshot) begin
          o_done_set = 1'b1;
          o_q_next   = ZERO;
        end else begin
          o_q_next = i_mod;
        end
      end else if (i_q > i_mod) begin
        o_q_next = i_mod;
      end else begin
        o_q_next = i_q - ONE;
      end
    end
  end

endmodule

// File: rtl/prog_mod_counter.sv
// WIDTH-bit up/down counter with programmable modulus, one-shot halt, registered
// terminal pulse and compare flag, and an ENT-gated ripple carry for cascading.
module prog_mod_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             SCLR,
  input  logic             LOAD_n,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] MOD,
  input  logic             UP,
  input  logic             ONESHOT,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] CMP,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             TC_PULSE,
  output logic             MATCH,
  output logic             DONE
);

  logic [WIDTH-1:0] r_q;
  state_t           r_state;
  logic             r_tc;
  logic             r_match;

  logic [WIDTH-1:0] w_q_step;
  logic             w_term;
  logic             w_done_set;
  logic             w_step;
  logic [WIDTH-1:0] w_q_nxt;
  state_t           w_state_nxt;
  logic             w_tc_nxt;
  logic [WIDTH-1:0] w_term_val;

  counter_next_state #(
    .WIDTH(WIDTH)
  ) u_next (
    .i_q       (r_q),
    .i_mod     (MOD),
    .i_up      (UP),
    .i_oneshot (ONESHOT),
    .o_q_next  (w_q_step),
    .o_term    (w_term),
    .o_done_set(w_done_set)
  );

  // Edge priority: clear, then load, then a count step, else hold.
  always_comb begin
    w_step      = ENP & ENT & (r_state == RUN);
    w_q_nxt     = r_q;
    w_state_nxt = r_state;
    w_tc_nxt    = 1'b0;
    if (SCLR) begin
      w_q_nxt     = RESET_VAL;
      w_state_nxt = RUN;
    end else if (!LOAD_n) begin
      w_q_nxt     = D;
      w_state_nxt = RUN;
    end else if (w_step) begin
      w_q_nxt  = w_q_step;
      w_tc_nxt = w_term;
      if (w_done_set) begin
        w_state_nxt = HALT;
      end else begin
        w_state_nxt = r_state;
      end
    end else begin
      w_q_nxt = r_q;
    end
  end

  // MATCH is taken from the value Q is about to hold, so it lines up with Q.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_q     <= RESET_VAL;
      r_state <= RUN;
      r_tc    <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_state <= w_state_nxt;
      r_tc    <= w_tc_nxt;
      r_match <= (w_q_nxt == CMP);
    end
  end

  assign w_term_val = (UP == DIR_UP) ? MOD : {WIDTH{1'b0}};

  assign Q        = r_q;
  assign TC_PULSE = r_tc;
  assign MATCH    = r_match;
  assign DONE     = (r_state == HALT);
  assign RCO      = ENT & (r_q == w_term_val) & (r_state == RUN);

endmodule
